// File: rtl/btn_pkg.sv
// Shared types and constants for the front-panel button controller.
package btn_pkg;

  // History pattern that marks a fresh press: two high samples after a low one.
  localparam logic [1:0] H_PRESS_NEW = 2'b11;
  localparam logic       H_PRESS_OLD = 1'b0;

  function automatic int unsigned BTN_ID_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_sample_cell.sv
// Per-button sample history and press detector.
module btn_sample_cell
  import btn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic eval_tick,
  input  logic btn_raw,
  output logic press
);

  logic [2:0] h;

  // Newest sample enters at bit 2; press is evaluated one cycle after the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h     <= '0;
      press <= 1'b0;
    end else begin
      if (sample_tick) h <= {btn_raw, h[2:1]};
      press <= eval_tick && (h[2:1] == H_PRESS_NEW) && (h[0] == H_PRESS_OLD);
    end
  end

endmodule

// File: rtl/btn_event_sched.sv
// Button front end: sample divider, per-button debounce cells, round-robin
// press arbiter and a small event FIFO with a valid/ready output.
module btn_event_sched
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BTN-1:0]           btn_raw,
  output logic                       evt_valid,
  output logic [BTN_ID_W(N_BTN)-1:0] evt_id,
  input  logic                       evt_ready,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic                       sample_tick
);

  localparam int unsigned ID_W  = BTN_ID_W(N_BTN);
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DIV_W-1:0] div_cnt;
  logic             eval_tick;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] drop;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_found;
  logic             gnt;

  logic [ID_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [ID_W-1:0]  head_n;
  logic             full;
  logic             pop;

  // Sample divider; the tick is registered one count early so it lines up with SAMPLE_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
      eval_tick   <= 1'b0;
    end else begin
      div_cnt     <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      sample_tick <= (div_cnt == DIV_W'(SAMPLE_DIV - 2));
      eval_tick   <= sample_tick;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    btn_sample_cell u_cell (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .eval_tick   (eval_tick),
      .btn_raw     (btn_raw[i]),
      .press       (press[i])
    );
  end

  // Round-robin search starting one past the last granted button.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      cand = ID_W'((32'(last) + k + 1) % N_BTN);
      if (!gnt_found && pend[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign gnt  = gnt_found && !full;
  assign pop  = evt_valid && evt_ready;

  always_comb begin
    clr = '0;
    if (gnt) clr[gnt_id] = 1'b1;
  end

  assign drop = press & pend & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      last <= ID_W'(N_BTN - 1);
      ovf  <= 1'b0;
    end else begin
      pend <= press | (pend & ~clr);
      if (gnt) last <= gnt_id;
      if (|drop)        ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Next head: bypass the pushed id when it lands in an otherwise empty FIFO.
  always_comb begin
    count_n  = count + CNT_W'(gnt) - CNT_W'(pop);
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    head_n   = '0;
    if (count_n != '0) begin
      if (gnt && (count == CNT_W'(pop))) head_n = gnt_id;
      else                               head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      if (gnt) begin
        mem[wr_ptr] <= gnt_id;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      evt_valid <= (count_n != '0);
      evt_id    <= head_n;
    end
  end

endmodule
